// File: rtl/pool_window_gen.sv
// pool_window_gen
// Turns a row-major stream of conv pixels (all channel lanes in one beat) into
// a sequence of 2x2 pooling windows. Each window goes out as four beats:
// the two pixels of the even row from the line buffer, then the held pixel
// and the current pixel of the odd row.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous frame abort; wins over in_valid in the same cycle
//   in_valid/in_ready/in_data   pixel input, accepted when in_valid & in_ready
//   aa_en, aa_first_data, aa_last_data   registered window beat flags
//   data_o         beat data, one cycle behind its flags, zero otherwise
//   frame_done     one-cycle pulse after the last window of a frame
//   busy           high from the first accepted pixel until frame_done
//
// Handshake: in_valid/in_ready follow strict valid/ready semantics. A pixel
// transfers on a rising clk edge where in_valid and in_ready are both high
// and clr is low. in_ready depends only on registered state, never on
// in_valid, and is low for the four EMIT cycles of every window.
//
// Lane l occupies in_data[(INPUT_NUM-1-l)*WD +: WD], so lane 0 sits in the
// most-significant bits. Lanes are moved verbatim; nothing is computed on them.

`ifndef WD
`define WD 8
`endif

module pool_window_gen #(
  parameter int INPUT_NUM = 6,
  parameter int FM_W      = 28,
  parameter int FM_H      = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`WD*INPUT_NUM-1:0]  in_data,
  output logic                      aa_en,
  output logic                      aa_first_data,
  output logic                      aa_last_data,
  output logic [`WD*INPUT_NUM-1:0]  data_o,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int DW = `WD * INPUT_NUM;
  localparam int CW = $clog2(FM_W);
  localparam int RW = $clog2(FM_H);
  localparam logic [CW-1:0] COL_LAST = CW'(FM_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FM_H - 1);

  typedef enum logic [1:0] {
    ST_EVEN = 2'd0,
    ST_ODD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [1:0]      beat;

  logic [DW-1:0]   lbuf [FM_W];
  logic [DW-1:0]   hold_q;
  logic [DW-1:0]   pix_q;

  logic            accept;
  logic            col_last;
  logic            row_last;
  logic [DW-1:0]   beat_data;

  assign in_ready = (state != ST_EMIT);
  assign accept   = in_valid & in_ready & ~clr;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // During EMIT the counters still point at the odd pixel (r,c) that opened
  // the window; they only advance once the fourth beat has been issued.
  always_comb begin
    beat_data = '0;
    case (beat)
      2'd0:    beat_data = lbuf[col - CW'(1)];
      2'd1:    beat_data = lbuf[col];
      2'd2:    beat_data = hold_q;
      default: beat_data = pix_q;
    endcase
  end

  // Pixel storage carries no reset: its contents are never observed before
  // being rewritten in the current frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == ST_EVEN) begin
        lbuf[col] <= in_data;
      end else if (!col[0]) begin
        hold_q <= in_data;
      end else begin
        pix_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_EVEN;
      col           <= '0;
      row           <= '0;
      beat          <= '0;
      aa_en         <= 1'b0;
      aa_first_data <= 1'b0;
      aa_last_data  <= 1'b0;
      data_o        <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else if (clr) begin
      state         <= ST_EVEN;
      col           <= '0;
      row           <= '0;
      beat          <= '0;
      aa_en         <= 1'b0;
      aa_first_data <= 1'b0;
      aa_last_data  <= 1'b0;
      data_o        <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Data trails the flags by one cycle: sample the beat chosen this cycle.
      data_o     <= (state == ST_EMIT) ? beat_data : '0;
      if (accept) begin
        busy <= 1'b1;
      end

      case (state)
        ST_EVEN: begin
          if (accept) begin
            if (col_last) begin
              col   <= '0;
              row   <= row + RW'(1);
              state <= ST_ODD;
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        ST_ODD: begin
          if (accept) begin
            if (col[0]) begin
              state         <= ST_EMIT;
              beat          <= '0;
              aa_en         <= 1'b1;
              aa_first_data <= 1'b1;
              aa_last_data  <= 1'b0;
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        ST_EMIT: begin
          aa_first_data <= 1'b0;
          if (beat == 2'd3) begin
            aa_en        <= 1'b0;
            aa_last_data <= 1'b0;
            beat         <= '0;
            if (col_last) begin
              col   <= '0;
              state <= ST_EVEN;
              if (row_last) begin
                row        <= '0;
                frame_done <= 1'b1;
                busy       <= 1'b0;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col   <= col + CW'(1);
              state <= ST_ODD;
            end
          end else begin
            beat         <= beat + 2'd1;
            aa_last_data <= (beat == 2'd2);
          end
        end

        default: state <= ST_EVEN;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Testbench for pool_window_gen on a 4x4 map with six 8-bit lanes.
// The reference model lists every window's four beats straight from the
// frame array in window order, plus the per-lane signed maximum of each
// window, and a per-cycle expectation of the handshake and flag timing.

`ifndef WD
`define WD 8
`endif

module tb_pool_window_gen;

  localparam int N  = 6;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WD = `WD;
  localparam int DW = WD * N;

  // clock / reset / DUT
  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          aa_en;
  logic          aa_first_data;
  logic          aa_last_data;
  logic [DW-1:0] data_o;
  logic          frame_done;
  logic          busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pool_window_gen #(
    .INPUT_NUM (N),
    .FM_W      (W),
    .FM_H      (H)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .aa_en         (aa_en),
    .aa_first_data (aa_first_data),
    .aa_last_data  (aa_last_data),
    .data_o        (data_o),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int            checks;
  int            errors;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pool_q[$];
  logic [DW-1:0] fr [W*H];
  int            pix_cnt;
  int            ready_low_left;
  int            frames;
  int            obs_beat;
  bit            prev_en;
  bit            prev_last;
  logic [DW-1:0] pool_acc;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout/empty expected event", tag);
  endtask

  function automatic logic [WD-1:0] lane(input logic [DW-1:0] b, input int l);
    return b[(N-1-l)*WD +: WD];
  endfunction

  function automatic logic [DW-1:0] max_bus(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] m;
    m = '0;
    for (int l = 0; l < N; l++) begin
      m[(N-1-l)*WD +: WD] = ($signed(lane(a, l)) > $signed(lane(b, l))) ? lane(a, l) : lane(b, l);
    end
    return m;
  endfunction

  // frame patterns
  task automatic fill_ramp();
    for (int n = 0; n < W*H; n++) begin
      for (int l = 0; l < N; l++) fr[n][(N-1-l)*WD +: WD] = WD'(n);
    end
  endtask

  task automatic fill_mixed();
    logic [WD-1:0] pick [4];
    pick[0] = 8'h80;
    pick[1] = 8'hFF;
    pick[2] = 8'h7F;
    for (int n = 0; n < W*H; n++) begin
      pick[3] = WD'($urandom);
      for (int l = 0; l < N; l++) fr[n][(N-1-l)*WD +: WD] = pick[(n + l + $urandom_range(0, 1)) % 4];
    end
  endtask

  task automatic fill_random();
    for (int n = 0; n < W*H; n++) begin
      for (int l = 0; l < N; l++) fr[n][(N-1-l)*WD +: WD] = WD'($urandom);
    end
  endtask

  // Reference: windows in raster order of their odd corner (r,c).
  task automatic push_model();
    logic [DW-1:0] a, b, c2, d;
    for (int r = 1; r < H; r += 2) begin
      for (int c = 1; c < W; c += 2) begin
        a  = fr[(r-1)*W + c-1];
        b  = fr[(r-1)*W + c];
        c2 = fr[r*W + c-1];
        d  = fr[r*W + c];
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c2);
        exp_q.push_back(d);
        pool_q.push_back(max_bus(max_bus(a, b), max_bus(c2, d)));
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pool_q.delete();
    pix_cnt        = 0;
    ready_low_left = 0;
    obs_beat       = 0;
    prev_en        = 1'b0;
    prev_last      = 1'b0;
  endtask

  // Per-cycle monitor, called just after a falling edge.
  task automatic monitor(input bit acc, input bit clr_now);
    bit            exp_done;
    bit            exp_en;
    int            k;
    int            r;
    int            c;
    logic [DW-1:0] e;
    if (clr_now) begin
      clear_model();
    end else if (acc) begin
      r = pix_cnt / W;
      c = pix_cnt % W;
      pix_cnt++;
      if ((r % 2 == 1) && (c % 2 == 1)) ready_low_left = 4;
    end
    exp_done = prev_last && (pix_cnt == W*H);
    if (exp_done) begin
      pix_cnt = 0;
      frames++;
    end
    exp_en = (ready_low_left > 0);
    k      = 4 - ready_low_left;
    chk("in_ready", in_ready, !exp_en);
    chk("aa_en", aa_en, exp_en);
    chk("aa_first_data", aa_first_data, exp_en && (k == 0));
    chk("aa_last_data", aa_last_data, exp_en && (k == 3));
    chk("frame_done", frame_done, exp_done);
    chk("busy", busy, pix_cnt != 0);
    if (prev_en) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", data_o, e);
        pool_acc = (obs_beat == 0) ? data_o : max_bus(pool_acc, data_o);
        if (obs_beat == 3) begin
          if (pool_q.size() == 0) fail_now("pool_empty");
          else chk("pool_max", pool_acc, pool_q.pop_front());
        end
        obs_beat = (obs_beat + 1) % 4;
      end
    end else begin
      chk("data_idle", data_o, '0);
    end
    prev_en   = exp_en;
    prev_last = exp_en && (k == 3);
    if (exp_en) ready_low_left--;
  endtask

  // driver tasks
  task automatic step(output bit acc);
    bit clr_now;
    acc     = in_valid && in_ready && !clr;
    clr_now = clr;
    @(posedge clk);
    @(negedge clk);
    monitor(acc, clr_now);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic do_reset();
    bit acc;
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("rst_aa_en", aa_en, 1'b0);
    chk("rst_aa_first", aa_first_data, 1'b0);
    chk("rst_aa_last", aa_last_data, 1'b0);
    chk("rst_data_o", data_o, '0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step(acc);
  endtask

  task automatic feed_pixels(input int first, input int last, input bit gaps);
    bit acc;
    int tries;
    for (int n = first; n <= last; n++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 60) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = in_valid ? fr[n] : DW'({$urandom, $urandom});
        step(acc);
        tries++;
      end
      if (!acc) fail_now("accept_timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit gaps);
    int f0;
    f0 = frames;
    push_model();
    feed_pixels(0, W*H-1, gaps);
    idle(8);
    chk("frames_done", frames, f0 + 1);
    chk("beats_left", exp_q.size(), 0);
  endtask

  // directed sequence
  initial begin
    int f0;
    bit acc;
    checks   = 0;
    errors   = 0;
    frames   = 0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    pool_acc = '0;
    do_reset();

    // reset in the middle of the first window's EMIT
    fill_random();
    push_model();
    feed_pixels(0, 5, 1'b0);
    idle(1);
    do_reset();

    // ramp frame, continuous valid (pooled maxima 5,7,13,15)
    fill_ramp();
    run_frame(1'b0);

    // same frame with random valid gaps
    run_frame(1'b1);

    // extreme signed lane values
    fill_mixed();
    run_frame(1'b1);
    fill_mixed();
    run_frame(1'b0);

    // clr during window 2's EMIT
    fill_random();
    push_model();
    f0 = frames;
    feed_pixels(0, 7, 1'b0);
    idle(1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'({$urandom, $urandom});
    step(acc);
    clr      = 1'b0;
    in_valid = 1'b0;
    idle(8);
    chk("clr_no_frame_done", frames, f0);
    fill_random();
    run_frame(1'b1);

    // a few more random frames
    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_frame(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
